// File: rtl/led_cmd_parser.sv
// led_cmd_parser
//   Framed command decoder sitting between a UART byte receiver and the
//   per-LED PWM brightness registers. Frames are four bytes:
//   SYNC_BYTE, ID, VAL, CHK where CHK = SYNC_BYTE ^ ID ^ VAL.
//   A good frame yields one WR_EN pulse. Every completed frame
//   (good, bad checksum, bad ID) yields a one-byte ACK/NAK on a
//   one-deep valid/ready response register. An inter-byte timeout
//   abandons stalled frames.
//
// Ports
//   CLK         system clock
//   RST_N       asynchronous active-low reset
//   RX_DATA     received byte, qualified by RX_VALID
//   RX_VALID    one-cycle strobe per received byte
//   WR_EN       one-cycle brightness register write strobe
//   WR_ID       LED ID of the last write (held between strobes)
//   WR_VALUE    brightness of the last write (held between strobes)
//   RESP_DATA   response byte: 8'h06 ACK, 8'h15 checksum NAK, 8'h18 bad-ID NAK
//   RESP_VALID  response pending
//   RESP_READY  transmitter accepts RESP_DATA
//   ERR_COUNT   saturating error counter (checksum, bad ID, timeout)

module led_cmd_parser #(
  parameter int          CLK_FREQ   = 12_000_000,
  parameter int          TIMEOUT_US = 2000,
  parameter int          NUM_LEDS   = 3,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       WR_EN,
  output logic [1:0] WR_ID,
  output logic [7:0] WR_VALUE,
  output logic [7:0] RESP_DATA,
  output logic       RESP_VALID,
  input  logic       RESP_READY,
  output logic [7:0] ERR_COUNT
);

  localparam int TIMEOUT_CYCLES = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
  localparam int CNT_BITS       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W          = (CNT_BITS > 15) ? CNT_BITS : 15;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       NUM_LEDS_B   = 8'(NUM_LEDS);

  localparam logic [7:0] RESP_ACK     = 8'h06;
  localparam logic [7:0] RESP_NAK_CHK = 8'h15;
  localparam logic [7:0] RESP_NAK_ID  = 8'h18;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_SYNC = 2'd1,
    GOT_ID   = 2'd2,
    GOT_VAL  = 2'd3
  } state_t;

  // Expected frame check byte: XOR of the three payload-carrying bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] sync_b,
                                           input logic [7:0] id_b,
                                           input logic [7:0] val_b);
    return sync_b ^ id_b ^ val_b;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] tmo_cnt_r;
  logic [7:0]       id_r;
  logic [7:0]       val_r;

  logic             frame_done_s;
  logic             chk_ok_s;
  logic             id_ok_s;
  logic             write_s;
  logic             timeout_s;
  logic             err_inc_s;
  logic [7:0]       resp_code_s;

  // Frame outcome decode and timeout detection for the current cycle.
  always_comb begin
    frame_done_s = 1'b0;
    chk_ok_s     = 1'b0;
    id_ok_s      = 1'b0;
    write_s      = 1'b0;
    timeout_s    = 1'b0;
    err_inc_s    = 1'b0;
    resp_code_s  = RESP_ACK;

    frame_done_s = (state_r == GOT_VAL) && RX_VALID;
    chk_ok_s     = (RX_DATA == frame_chk(SYNC_BYTE, id_r, val_r));
    id_ok_s      = (id_r < NUM_LEDS_B);

    // Checksum failure takes precedence over a bad ID.
    if (!chk_ok_s) begin
      resp_code_s = RESP_NAK_CHK;
    end else if (!id_ok_s) begin
      resp_code_s = RESP_NAK_ID;
    end else begin
      resp_code_s = RESP_ACK;
    end

    write_s = frame_done_s && chk_ok_s && id_ok_s;

    // A byte arriving on the timeout cycle wins over the timeout.
    timeout_s = (state_r != IDLE) && !RX_VALID && (tmo_cnt_r == TIMEOUT_LAST);

    // Timeout and frame completion are mutually exclusive, so at most one
    // increment request per cycle.
    err_inc_s = timeout_s || (frame_done_s && !(chk_ok_s && id_ok_s));
  end

  // Frame FSM with registered write, response and error outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= IDLE;
      tmo_cnt_r  <= '0;
      id_r       <= 8'h00;
      val_r      <= 8'h00;
      WR_EN      <= 1'b0;
      WR_ID      <= 2'd0;
      WR_VALUE   <= 8'h00;
      RESP_DATA  <= 8'h00;
      RESP_VALID <= 1'b0;
      ERR_COUNT  <= 8'h00;
    end else begin
      WR_EN <= 1'b0;

      case (state_r)
        IDLE: begin
          // Non-sync bytes in IDLE are dropped without any report.
          if (RX_VALID && (RX_DATA == SYNC_BYTE)) begin
            state_r <= GOT_SYNC;
          end else begin
            state_r <= IDLE;
          end
        end
        GOT_SYNC: begin
          // No mid-frame resync: a sync value here is just an ID.
          if (RX_VALID) begin
            id_r    <= RX_DATA;
            state_r <= GOT_ID;
          end else if (timeout_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= GOT_SYNC;
          end
        end
        GOT_ID: begin
          if (RX_VALID) begin
            val_r   <= RX_DATA;
            state_r <= GOT_VAL;
          end else if (timeout_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= GOT_ID;
          end
        end
        GOT_VAL: begin
          if (RX_VALID) begin
            state_r <= IDLE;
            if (write_s) begin
              WR_EN    <= 1'b1;
              WR_ID    <= id_r[1:0];
              WR_VALUE <= val_r;
            end else begin
              WR_EN    <= 1'b0;
            end
          end else if (timeout_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= GOT_VAL;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      // Inter-byte timer: only runs while a frame is partially received.
      if (RX_VALID || (state_r == IDLE) || timeout_s) begin
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      end

      // One-deep response register; a new response overrides both a
      // pending one and a same-cycle handshake.
      if (frame_done_s) begin
        RESP_DATA  <= resp_code_s;
        RESP_VALID <= 1'b1;
      end else if (RESP_VALID && RESP_READY) begin
        RESP_VALID <= 1'b0;
      end else begin
        RESP_VALID <= RESP_VALID;
      end

      // Saturating error counter.
      if (err_inc_s && (ERR_COUNT != 8'hFF)) begin
        ERR_COUNT <= ERR_COUNT + 8'd1;
      end else begin
        ERR_COUNT <= ERR_COUNT;
      end
    end
  end

endmodule
